// File: rtl/ysyx_22040759_rf_scoreboard_pkg.sv
// Shared constants and the WB-to-regfile bus layout for the register-file scoreboard.
package ysyx_22040759_rf_scoreboard_pkg;

    localparam int REG_AW          = 5;
    localparam int SB_CNT_W        = 2;
    localparam int INFL_W          = 3;
    localparam int RF_BUS_W        = 70;
    localparam int RF_BUS_WEN      = 69;
    localparam int RF_BUS_WADDR_HI = 68;
    localparam int RF_BUS_WADDR_LO = 64;

    typedef struct packed {
        logic              wen;
        logic [REG_AW-1:0] waddr;
        logic [63:0]       wdata;
    } rf_bus_t;

endpackage

// File: rtl/ysyx_22040759_sb_entry.sv
// One per-register pending-write counter: saturating up/down, with zero/one/max flags.
module ysyx_22040759_sb_entry
    import ysyx_22040759_rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_is_zero,
    output logic o_is_one,
    output logic o_is_max
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec_ok;

    assign o_is_zero = (r_cnt == '0);
    assign o_is_one  = (r_cnt == CNT_W'(1));
    assign o_is_max  = &r_cnt;

    // A retire against an empty counter is an error reported upstream; it must not wrap.
    assign w_dec_ok  = i_dec & ~o_is_zero;

    // NOTE: non-blocking assignment so every counter updates from its pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({i_inc, w_dec_ok})
                2'b10:   if (!o_is_max) r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22040759_rf_scoreboard.sv
// Register-file write scoreboard: tracks unretired writes per register and gates ID hand-off.
module ysyx_22040759_rf_scoreboard
    import ysyx_22040759_rf_scoreboard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int CNT_W     = SB_CNT_W,
    parameter int WB_BYPASS = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ds_valid,
    input  logic [REG_AW-1:0]   ds_rs1,
    input  logic                ds_rs1_ren,
    input  logic [REG_AW-1:0]   ds_rs2,
    input  logic                ds_rs2_ren,
    input  logic [REG_AW-1:0]   ds_rd,
    input  logic                ds_rd_wen,
    input  logic                es_allowin,
    input  logic [RF_BUS_W-1:0] ws_to_rf_bus,
    output logic                ds_ready_go,
    output logic [NREG-1:0]     sb_busy,
    output logic [INFL_W-1:0]   sb_inflight,
    output logic                sb_err
);

    rf_bus_t           w_bus;
    logic              w_retire;
    logic [REG_AW-1:0] w_raddr;
    logic              w_unused_wdata;
    logic              w_issue;
    logic              w_ret_eff;
    logic              w_ret_empty;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_sat;

    logic [NREG-1:0]   w_is_zero;
    logic [NREG-1:0]   w_is_one;
    logic [NREG-1:0]   w_is_max;

    logic [INFL_W-1:0] r_inflight;
    logic              r_err;

    assign w_bus          = ws_to_rf_bus;
    assign w_raddr        = w_bus.waddr;
    assign w_retire       = w_bus.wen & (w_bus.waddr != '0);
    assign w_unused_wdata = ^w_bus.wdata;

    // x0 has no counter: it always reads as empty and can never stall or saturate.
    assign w_is_zero[0] = 1'b1;
    assign w_is_one[0]  = 1'b0;
    assign w_is_max[0]  = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_entry
        ysyx_22040759_sb_entry #(
            .CNT_W     (CNT_W)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .i_inc     (w_issue  && (ds_rd   == REG_AW'(i))),
            .i_dec     (w_retire && (w_raddr == REG_AW'(i))),
            .o_is_zero (w_is_zero[i]),
            .o_is_one  (w_is_one[i]),
            .o_is_max  (w_is_max[i])
        );
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_hz1 = 1'b0;
        w_hz2 = 1'b0;
        w_sat = 1'b0;
        if (ds_rs1_ren && (ds_rs1 != '0) && !w_is_zero[ds_rs1]) begin
            w_hz1 = !((WB_BYPASS != 0) && w_retire && (w_raddr == ds_rs1) && w_is_one[ds_rs1]);
        end
        if (ds_rs2_ren && (ds_rs2 != '0) && !w_is_zero[ds_rs2]) begin
            w_hz2 = !((WB_BYPASS != 0) && w_retire && (w_raddr == ds_rs2) && w_is_one[ds_rs2]);
        end
        // A full counter may still accept a write if the same register retires this cycle.
        if (ds_rd_wen && (ds_rd != '0) && w_is_max[ds_rd]) begin
            w_sat = !(w_retire && (w_raddr == ds_rd));
        end
    end

    assign ds_ready_go = ~(w_hz1 | w_hz2 | w_sat);
    assign w_issue     = ds_valid & ds_ready_go & es_allowin & ds_rd_wen & (ds_rd != '0);

    // Only retires that actually drain a counter move the in-flight total.
    assign w_ret_eff   = w_retire & ~w_is_zero[w_raddr];
    assign w_ret_empty = w_retire &  w_is_zero[w_raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_issue && !w_ret_eff) begin
                r_inflight <= r_inflight + INFL_W'(1);
            end else if (!w_issue && w_ret_eff) begin
                r_inflight <= r_inflight - INFL_W'(1);
            end
            if (w_ret_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sb_busy     = ~w_is_zero;
    assign sb_inflight = r_inflight;
    assign sb_err      = r_err;

endmodule
